// File: rtl/bcd_digit_multiplier_if.sv
// Operand/result bundle for the single-digit BCD multiplier.
// Handshake: master raises start for one cycle with x/y while busy=0; the slave answers
// with a one-cycle done pulse, after which out/error stay valid until the next done.
interface bcd_digit_multiplier_if;
  logic       start;
  logic [3:0] x;
  logic [3:0] y;
  logic [7:0] out;
  logic       error;
  logic       busy;
  logic       done;
  logic [2:0] state;

  modport master (
    output start, x, y,
    input  out, error, busy, done, state
  );

  modport slave (
    input  start, x, y,
    output out, error, busy, done, state
  );
endinterface

// File: rtl/bcd_digit_multiplier.sv
// Sequential BCD digit multiplier: 4-cycle shift-add multiply, then 7-cycle
// double-dabble conversion of the binary product to two packed BCD digits.
module bcd_digit_multiplier (
  input  logic                   clk,
  input  logic                   rst,
  bcd_digit_multiplier_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    CONV = 3'd2,
    FIN  = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  x_reg;
  logic [3:0]  y_reg;
  logic [6:0]  acc;
  logic [6:0]  acc_next;
  logic [14:0] dd;
  logic [14:0] dd_adj;
  logic [14:0] dd_next;
  logic [2:0]  cnt;
  logic [7:0]  out_reg;
  logic        error_reg;
  logic        done_reg;
  logic        bad_operand;

  assign bad_operand = (bus.x > 4'd9) || (bus.y > 4'd9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start) state_next = bad_operand ? ERR : MUL;
      MUL:  if (cnt == 3'd3) state_next = CONV;
      CONV: if (cnt == 3'd6) state_next = FIN;
      FIN:  state_next = IDLE;
      ERR:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One multiplier bit per cycle, LSB first; bit index is the cycle count.
  always_comb begin
    acc_next = acc;
    if (y_reg[cnt[1:0]]) acc_next = acc + ({3'b000, x_reg} << cnt[1:0]);
  end

  // Double dabble: {tens, units, binary} shifted left after nibble correction.
  always_comb begin
    dd_adj = dd;
    if (dd_adj[10:7] >= 4'd5)  dd_adj[10:7]  = dd_adj[10:7] + 4'd3;
    if (dd_adj[14:11] >= 4'd5) dd_adj[14:11] = dd_adj[14:11] + 4'd3;
    dd_next = {dd_adj[13:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg     <= 4'd0;
      y_reg     <= 4'd0;
      acc       <= 7'd0;
      dd        <= 15'd0;
      cnt       <= 3'd0;
      out_reg   <= 8'h00;
      error_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            x_reg <= bus.x;
            y_reg <= bus.y;
            acc   <= 7'd0;
            cnt   <= 3'd0;
          end
        end
        MUL: begin
          acc <= acc_next;
          if (cnt == 3'd3) begin
            dd  <= {8'h00, acc_next};
            cnt <= 3'd0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        CONV: begin
          dd  <= dd_next;
          cnt <= cnt + 3'd1;
        end
        FIN: begin
          out_reg   <= dd[14:7];
          error_reg <= 1'b0;
          done_reg  <= 1'b1;
        end
        ERR: begin
          out_reg   <= 8'h00;
          error_reg <= 1'b1;
          done_reg  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.out   = out_reg;
  assign bus.error = error_reg;
  assign bus.done  = done_reg;
  assign bus.busy  = (state != IDLE);
  assign bus.state = state;

endmodule

// File: tb/tb_bcd_digit_multiplier.sv
// Directed bench for bcd_digit_multiplier: driver pushes expected {error,out}
// into a queue; a negedge monitor pops and compares on every done pulse.
module tb_bcd_digit_multiplier;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  logic [8:0] exp_q[$];

  bcd_digit_multiplier_if bus ();

  bcd_digit_multiplier dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1, expected no pending result at %0t", $time);
      end else begin
        check("result", {23'd0, bus.error, bus.out}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_done(input int lat);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, lat);
    check("busy_at_done", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [8:0] exp, input int lat);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.x     = a;
    bus.y     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.x     = 4'($urandom_range(0, 15));
    bus.y     = 4'($urandom_range(0, 15));
    check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    wait_done(lat);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [8:0] exp;
    int         lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    tests = 0;
    fails = 0;
    vecs[0]  = '{4'd3,  4'd2,  9'h006, 12};
    vecs[1]  = '{4'd9,  4'd9,  9'h081, 12};
    vecs[2]  = '{4'd5,  4'd4,  9'h020, 12};
    vecs[3]  = '{4'd1,  4'd0,  9'h000, 12};
    vecs[4]  = '{4'd4,  4'd2,  9'h008, 12};
    vecs[5]  = '{4'd2,  4'd4,  9'h008, 12};
    vecs[6]  = '{4'd10, 4'd0,  9'h100, 1};
    vecs[7]  = '{4'd3,  4'd2,  9'h006, 12};
    vecs[8]  = '{4'd0,  4'd15, 9'h100, 1};
    vecs[9]  = '{4'd7,  4'd6,  9'h042, 12};
    vecs[10] = '{4'd8,  4'd7,  9'h056, 12};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.x     = 4'd0;
    bus.y     = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out",   {24'd0, bus.out}, 32'h00);
    check("reset_error", {31'd0, bus.error}, 32'd0);
    check("reset_busy",  {31'd0, bus.busy}, 32'd0);
    check("reset_done",  {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Start pulsed while busy must be ignored; first result held afterwards.
    exp_q.push_back(9'h006);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.x = 4'd3; bus.y = 4'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.x = 4'd9; bus.y = 4'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(8);
    repeat (20) @(posedge clk);
    #1;
    check("hold_out",   {24'd0, bus.out}, 32'h06);
    check("hold_error", {31'd0, bus.error}, 32'd0);

    // Reset during CONV aborts: outputs clear at once, no done follows.
    run_op(4'd9, 4'd9, 9'h081, 12);
    exp_q.push_back(9'h081);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.x = 4'd9; bus.y = 4'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("conv_state", {29'd0, bus.state}, 32'd2);
    rst = 1'b1;
    #1;
    check("abort_out",   {24'd0, bus.out}, 32'h00);
    check("abort_error", {31'd0, bus.error}, 32'd0);
    check("abort_busy",  {31'd0, bus.busy}, 32'd0);
    check("abort_done",  {31'd0, bus.done}, 32'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    run_op(4'd3, 4'd2, 9'h006, 12);

    repeat (5) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
